pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central sequencer for the five-stage RISC-V pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It drives every stage register's `enable` and a per-stage synchronous flush. It resolves three events: a data-memory wait, a taken branch, and a load-use hazard. A registered FSM provides post-reset hold, multi-cycle memory wait with timeout, and a sticky error flag.

## Interface
- `RESET_HOLD`, default 2: cycles after reset release during which the pipeline stays frozen and flushed (1..15).
- `MEM_TIMEOUT`, default 16: maximum wait-state cycles per data-memory access before forced release (2..255).
- `XLEN`, default from `RISCV.h`: sizes the performance counters.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `id_ex_MemRead`  in  1  load instruction in EX.
- `id_ex_WriteReg`  in  5  destination register of the EX instruction.
- `if_id_rs1`, `if_id_rs2`  in  5 each  source registers of the ID instruction.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump.
- `ex_mem_MemAccess`  in  1  load or store in MEM.
- `dmem_ready`  in  1  data memory completes the MEM access this cycle.
- `pc_enable`, `if_id_enable`, `id_ex_enable`, `ex_mem_enable`, `mem_wb_enable`  out  1 each  stage register enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush`  out  1 each  bubble insert; the integrator ORs each into that register's `reset`.
- `mem_error`  out  1  sticky; set when a memory timeout occurs.

## Operation
- FSM states: HOLD, RUN, MEM_WAIT. A wait counter `wcnt` is 8 bits wide.
- **Reset:**
  - State goes to HOLD and `wcnt` is loaded with `RESET_HOLD-1`. `mem_error` clears to 0.
  - While `reset` is high, all enables are 0 and all flushes are 1.
- **HOLD:**
  - All enables are 0 and all flushes are 1.
  - `wcnt` decrements each cycle. At 0, the next state is RUN.
- **RUN**, priority top-down:
  1. **Memory stall**, when `ex_mem_MemAccess & !dmem_ready`:
     - All enables are 0 and `mem_wb_flush` is 1.
     - Next state is MEM_WAIT with `wcnt` = 1.
  2. **Taken branch**, when `ex_branch_taken`:
     - All enables are 1.
     - `if_id_flush` and `id_ex_flush` are 1.
  3. **Load-use hazard**, when `id_ex_MemRead`, `id_ex_WriteReg` != 0, and `id_ex_WriteReg` equals `if_id_rs1` or `if_id_rs2`:
     - `pc_enable` and `if_id_enable` are 0.
     - `id_ex_flush` is 1.
     - `id_ex_enable`, `ex_mem_enable` and `mem_wb_enable` are 1.
  4. **Otherwise:** all enables are 1 and all flushes are 0.
- **MEM_WAIT:**
  - If `dmem_ready` is 0 and `wcnt` < `MEM_TIMEOUT`:
    - Behaves as RUN case 1 and stays in MEM_WAIT.
    - `wcnt` increments.
  - If `dmem_ready` is 1, or `wcnt` == `MEM_TIMEOUT`:
    - This is the release cycle. RUN priorities 2–4 apply and the next state is RUN.
    - On timeout only, `mem_error` is set.
- **Simultaneous events:**
  - A branch during a memory stall stays frozen in EX. It is acted on in the release cycle.
  - Branch and load-use together: the branch wins, and the hazard instruction is flushed.
- A hazard check against `x0` never stalls.

## Timing
- All enable and flush outputs are Mealy outputs: a combinational function of the current state and the current inputs, with zero-cycle latency. There are no combinational paths between outputs.
- State, `wcnt` and `mem_error` update on the rising edge of `clock`.
- A load-use stall lasts exactly 1 cycle: the next cycle, ID/EX holds a bubble with `id_ex_MemRead` = 0.
- A branch costs 2 bubbles.
- A memory access that is ready after N wait cycles freezes the pipeline for N cycles. The forced release at timeout happens at most `MEM_TIMEOUT` cycles after entering MEM_WAIT.
- `reset` asserted mid-MEM_WAIT aborts the wait without setting `mem_error`. The FSM restarts in HOLD.

## Configuration
- `PIPE_PERF_CNT_EN`, when defined, adds:
  - outputs `stall_cycles` and `flush_events`, `XLEN` bits each, both reset to 0;
  - `stall_cycles` increments on every cycle in which `pc_enable` = 0 outside HOLD and reset;
  - `flush_events` increments on every cycle in which `if_id_flush` or `id_ex_flush` = 1 outside HOLD and reset;
  - both counters wrap modulo 2^`XLEN`.
- When the macro is undefined, these ports and their logic are absent. All other behaviour is identical.

## Test plan
- **Reset and hold:** deassert `reset` with `RESET_HOLD`=2 -> all enables 0 and flushes 1 for 2 cycles, then all enables 1 and flushes 0.
- **Load-use hazard:** `id_ex_MemRead`=1, `id_ex_WriteReg`=5, `if_id_rs2`=5 -> for one cycle `pc_enable`=0, `if_id_enable`=0, `id_ex_flush`=1; next cycle normal. With `id_ex_WriteReg`=0 -> no stall.
- **Branch:** `ex_branch_taken`=1 together with the load-use hazard above -> `if_id_flush`=1, `id_ex_flush`=1, `pc_enable`=1.
- **Memory wait:** `ex_mem_MemAccess`=1 with `dmem_ready` going high after 3 cycles -> enables 0 and `mem_wb_flush`=1 for 3 cycles, release on the 4th cycle, `mem_error`=0.
- **Timeout:** `MEM_TIMEOUT`=4 with `dmem_ready` held at 0 -> forced release, then `mem_error`=1, which stays set until `reset`.
- **Counters** (`PIPE_PERF_CNT_EN` defined): the sequence of 1 load-use stall, 1 branch and a 3-cycle memory wait -> `stall_cycles`=4, `flush_events`=2.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard/stall inputs and stage enable/flush outputs of pipeline_ctrl
// slave is the sequencer side; master is the datapath/integration side.

interface pipeline_ctrl_if;
  logic       id_ex_MemRead;
  logic [4:0] id_ex_WriteReg;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       ex_branch_taken;
  logic       ex_mem_MemAccess;
  logic       dmem_ready;

  logic       pc_enable;
  logic       if_id_enable;
  logic       id_ex_enable;
  logic       ex_mem_enable;
  logic       mem_wb_enable;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mem_wb_flush;
  logic       mem_error;

  modport slave (
    input  id_ex_MemRead, id_ex_WriteReg, if_id_rs1, if_id_rs2,
    input  ex_branch_taken, ex_mem_MemAccess, dmem_ready,
    output pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
    output if_id_flush, id_ex_flush, mem_wb_flush, mem_error
  );

  modport master (
    output id_ex_MemRead, id_ex_WriteReg, if_id_rs1, if_id_rs2,
    output ex_branch_taken, ex_mem_MemAccess, dmem_ready,
    input  pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
    input  if_id_flush, id_ex_flush, mem_wb_flush, mem_error
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - five-stage pipeline sequencer: reset hold, memory wait/timeout, branch and load-use control
// Optional PIPE_PERF_CNT_EN adds stall_cycles / flush_events performance counters.

module pipeline_ctrl #(
  parameter int RESET_HOLD  = 2,
  parameter int MEM_TIMEOUT = 16
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int XLEN        = 32
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_ctrl_if.slave        bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]       stall_cycles,
  output logic [XLEN-1:0]       flush_events
`endif
);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_e;

  // Output behaviour for the current cycle; the release cycle of MEM_WAIT reuses O_RUN.
  typedef enum logic [1:0] {
    O_FREEZE = 2'd0,
    O_STALL  = 2'd1,
    O_RUN    = 2'd2
  } out_mode_e;

  localparam logic [7:0] HOLD_INIT = 8'(RESET_HOLD - 1);
  localparam logic [7:0] WAIT_MAX  = 8'(MEM_TIMEOUT);

  state_e    state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic      mem_error_q, mem_error_d;
  out_mode_e mode;

  logic mem_stall;
  logic load_use;
  logic wait_expired;

  assign mem_stall    = bus.ex_mem_MemAccess & ~bus.dmem_ready;
  assign load_use     = bus.id_ex_MemRead && (bus.id_ex_WriteReg != 5'd0) &&
                        ((bus.id_ex_WriteReg == bus.if_id_rs1) ||
                         (bus.id_ex_WriteReg == bus.if_id_rs2));
  assign wait_expired = (wcnt_q >= WAIT_MAX);

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_error_d = mem_error_q;
    mode        = O_RUN;
    unique case (state_q)
      S_HOLD: begin
        mode = O_FREEZE;
        if (wcnt_q == 8'd0) begin
          state_d = S_RUN;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      S_RUN: begin
        if (mem_stall) begin
          mode    = O_STALL;
          state_d = S_MEM_WAIT;
          wcnt_d  = 8'd1;
        end
      end
      S_MEM_WAIT: begin
        if (!bus.dmem_ready && !wait_expired) begin
          mode   = O_STALL;
          wcnt_d = wcnt_q + 8'd1;
        end else begin
          state_d = S_RUN;
          if (!bus.dmem_ready) begin
            mem_error_d = 1'b1;
          end
        end
      end
      default: begin
        mode    = O_FREEZE;
        state_d = S_HOLD;
        wcnt_d  = HOLD_INIT;
      end
    endcase
    if (reset) begin
      mode = O_FREEZE;
    end
  end

  always_comb begin
    bus.pc_enable     = 1'b1;
    bus.if_id_enable  = 1'b1;
    bus.id_ex_enable  = 1'b1;
    bus.ex_mem_enable = 1'b1;
    bus.mem_wb_enable = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_flush   = 1'b0;
    bus.mem_wb_flush  = 1'b0;
    unique case (mode)
      O_FREEZE: begin
        bus.pc_enable     = 1'b0;
        bus.if_id_enable  = 1'b0;
        bus.id_ex_enable  = 1'b0;
        bus.ex_mem_enable = 1'b0;
        bus.mem_wb_enable = 1'b0;
        bus.if_id_flush   = 1'b1;
        bus.id_ex_flush   = 1'b1;
        bus.mem_wb_flush  = 1'b1;
      end
      O_STALL: begin
        bus.pc_enable     = 1'b0;
        bus.if_id_enable  = 1'b0;
        bus.id_ex_enable  = 1'b0;
        bus.ex_mem_enable = 1'b0;
        bus.mem_wb_enable = 1'b0;
        bus.mem_wb_flush  = 1'b1;
      end
      default: begin
        // A taken branch squashes the load-use victim, so it outranks the hazard stall.
        if (bus.ex_branch_taken) begin
          bus.if_id_flush = 1'b1;
          bus.id_ex_flush = 1'b1;
        end else if (load_use) begin
          bus.pc_enable    = 1'b0;
          bus.if_id_enable = 1'b0;
          bus.id_ex_flush  = 1'b1;
        end
      end
    endcase
  end

  assign bus.mem_error = mem_error_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_HOLD;
      wcnt_q      <= HOLD_INIT;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_error_q <= mem_error_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [XLEN-1:0] stall_cycles_q, stall_cycles_d;
  logic [XLEN-1:0] flush_events_q, flush_events_d;
  logic            cnt_active;

  assign cnt_active = (state_q != S_HOLD);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (cnt_active && !bus.pc_enable) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (cnt_active && (bus.if_id_flush || bus.id_ex_flush)) begin
      flush_events_d = flush_events_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
// Output vector order: {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, mem_wb flushes}.

module tb_pipeline_ctrl;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  pipeline_ctrl_if pif();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
  pipeline_ctrl #(.RESET_HOLD(2), .MEM_TIMEOUT(4), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .bus(pif),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );
`else
  pipeline_ctrl #(.RESET_HOLD(2), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .bus(pif)
  );
`endif

  localparam logic [7:0] O_FREEZE = 8'b00000_111;
  localparam logic [7:0] O_STALL  = 8'b00000_001;
  localparam logic [7:0] O_NORMAL = 8'b11111_000;
  localparam logic [7:0] O_BRANCH = 8'b11111_110;
  localparam logic [7:0] O_LDUSE  = 8'b00111_010;

  logic [7:0] outs;
  assign outs = {pif.pc_enable, pif.if_id_enable, pif.id_ex_enable, pif.ex_mem_enable,
                 pif.mem_wb_enable, pif.if_id_flush, pif.id_ex_flush, pif.mem_wb_flush};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    pif.id_ex_MemRead    = 1'b0;
    pif.id_ex_WriteReg   = 5'd0;
    pif.if_id_rs1        = 5'd0;
    pif.if_id_rs2        = 5'd0;
    pif.ex_branch_taken  = 1'b0;
    pif.ex_mem_MemAccess = 1'b0;
    pif.dmem_ready       = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    #1 check({tag, "_reset_outs"}, 32'(outs), 32'(O_FREEZE));
    check({tag, "_reset_err"}, 32'(pif.mem_error), 32'd0);
    reset = 1'b0;
    #1 check({tag, "_hold0"}, 32'(outs), 32'(O_FREEZE));
    tick();
    #1 check({tag, "_hold1"}, 32'(outs), 32'(O_FREEZE));
    tick();
    #1 check({tag, "_run"}, 32'(outs), 32'(O_NORMAL));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    clear_inputs();

    do_reset("r1");

    // Load-use via rs2, then bubble cycle.
    pif.id_ex_MemRead = 1'b1; pif.id_ex_WriteReg = 5'd5; pif.if_id_rs1 = 5'd1; pif.if_id_rs2 = 5'd5;
    #1 check("lu_rs2", 32'(outs), 32'(O_LDUSE));
    tick();
    pif.id_ex_MemRead = 1'b0;
    #1 check("lu_after", 32'(outs), 32'(O_NORMAL));
    pif.id_ex_MemRead = 1'b1; pif.id_ex_WriteReg = 5'd7; pif.if_id_rs1 = 5'd7; pif.if_id_rs2 = 5'd3;
    #1 check("lu_rs1", 32'(outs), 32'(O_LDUSE));
    pif.id_ex_MemRead = 1'b0;
    #1 check("no_load", 32'(outs), 32'(O_NORMAL));
    pif.id_ex_MemRead = 1'b1; pif.id_ex_WriteReg = 5'd0; pif.if_id_rs1 = 5'd0; pif.if_id_rs2 = 5'd0;
    #1 check("lu_x0", 32'(outs), 32'(O_NORMAL));
    tick();

    // Branch together with load-use.
    pif.id_ex_WriteReg = 5'd5; pif.if_id_rs2 = 5'd5; pif.ex_branch_taken = 1'b1;
    #1 check("br_lu", 32'(outs), 32'(O_BRANCH));
    tick();
    clear_inputs();
    #1 check("br_after", 32'(outs), 32'(O_NORMAL));

    // Memory wait released by dmem_ready on the 4th cycle; branch held through it.
    pif.ex_mem_MemAccess = 1'b1; pif.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("mw_stall%0d", i), 32'(outs), 32'(O_STALL));
      tick();
    end
    pif.dmem_ready = 1'b1;
    #1 check("mw_release", 32'(outs), 32'(O_BRANCH));
    tick();
    clear_inputs();
    #1 check("mw_run", 32'(outs), 32'(O_NORMAL));
    check("mw_err", 32'(pif.mem_error), 32'd0);

    // Timeout with MEM_TIMEOUT=4: 4 stall cycles, forced release, sticky error.
    pif.ex_mem_MemAccess = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("to_stall%0d", i), 32'(outs), 32'(O_STALL));
      tick();
    end
    #1 check("to_release", 32'(outs), 32'(O_NORMAL));
    check("to_err_pre", 32'(pif.mem_error), 32'd0);
    tick();
    pif.ex_mem_MemAccess = 1'b0;
    #1 check("to_err_set", 32'(pif.mem_error), 32'd1);
    tick();
    tick();
    check("to_err_sticky", 32'(pif.mem_error), 32'd1);

    // Reset clears the error; then reset mid-wait aborts without flagging.
    do_reset("r2");
    pif.ex_mem_MemAccess = 1'b1;
    tick();
    tick();
    #1 check("ab_stall", 32'(outs), 32'(O_STALL));
    reset = 1'b1;
    #1 check("ab_reset_outs", 32'(outs), 32'(O_FREEZE));
    tick();
    reset = 1'b0;
    pif.ex_mem_MemAccess = 1'b0;
    #1 check("ab_hold", 32'(outs), 32'(O_FREEZE));
    check("ab_err", 32'(pif.mem_error), 32'd0);
    tick();
    tick();
    #1 check("ab_run", 32'(outs), 32'(O_NORMAL));
    check("ab_err2", 32'(pif.mem_error), 32'd0);

`ifdef PIPE_PERF_CNT_EN
    do_reset("r3");
    check("cnt_stall0", stall_cycles, 32'd0);
    check("cnt_flush0", flush_events, 32'd0);
    pif.id_ex_MemRead = 1'b1; pif.id_ex_WriteReg = 5'd5; pif.if_id_rs2 = 5'd5;
    tick();
    clear_inputs();
    pif.ex_branch_taken = 1'b1;
    tick();
    clear_inputs();
    pif.ex_mem_MemAccess = 1'b1;
    tick();
    tick();
    tick();
    pif.dmem_ready = 1'b1;
    tick();
    clear_inputs();
    check("cnt_stall", stall_cycles, 32'd4);
    check("cnt_flush", flush_events, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
